// File: rtl/alu_arbiter.sv
// Two-port front end for a shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC captures, RESP holds until consumed.
module alu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [31:0] req0_num1,
    input  logic [31:0] req0_num2,
    input  logic [4:0]  req0_shamt,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [31:0] req1_num1,
    input  logic [31:0] req1_num2,
    input  logic [4:0]  req1_shamt,

    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_result,
    output logic [2:0]  resp0_flags,

    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_result,
    output logic [2:0]  resp1_flags,

    output logic [4:0]  alu_op,
    output logic [31:0] alu_num1,
    output logic [31:0] alu_num2,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_sig_overflow,
    input  logic        alu_op_invalid,

    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_grant_q;
    logic        owner_q;
    logic [4:0]  op_q;
    logic [31:0] num1_q;
    logic [31:0] num2_q;
    logic [4:0]  shamt_q;
    logic [31:0] result_q;
    logic [2:0]  flags_q;
    logic [15:0] op_count_q;
    logic [15:0] op_count_d;
    logic        resp0_valid_q;
    logic        resp1_valid_q;
    logic        busy_q;

    logic        grant0;
    logic        grant1;
    logic        consume;

    // last_grant_q names the port that won most recently; a tie goes to the other one
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (FIXED_PRIO) begin
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
        end else if (req0_valid && req1_valid) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign consume    = owner_q ? resp1_ready : resp0_ready;
    assign op_count_d = op_count_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            op_q          <= '0;
            num1_q        <= '0;
            num2_q        <= '0;
            shamt_q       <= '0;
            result_q      <= '0;
            flags_q       <= '0;
            op_count_q    <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_q         <= grant1 ? req1_op    : req0_op;
                        num1_q       <= grant1 ? req1_num1  : req0_num1;
                        num2_q       <= grant1 ? req1_num2  : req0_num2;
                        shamt_q      <= grant1 ? req1_shamt : req0_shamt;
                        owner_q      <= grant1;
                        last_grant_q <= grant1;
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q      <= alu_result;
                    flags_q       <= {alu_op_invalid, alu_sig_overflow, alu_overflow};
                    resp0_valid_q <= !owner_q;
                    resp1_valid_q <= owner_q;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (consume) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        op_count_q    <= op_count_d;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    resp0_valid_q <= 1'b0;
                    resp1_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held, not only after the reset edge
    assign req0_ready   = reset_n && (state_q == IDLE) && grant0;
    assign req1_ready   = reset_n && (state_q == IDLE) && grant1;

    assign resp0_valid  = reset_n && resp0_valid_q;
    assign resp1_valid  = reset_n && resp1_valid_q;
    assign resp0_result = reset_n ? result_q : '0;
    assign resp1_result = reset_n ? result_q : '0;
    assign resp0_flags  = reset_n ? flags_q  : '0;
    assign resp1_flags  = reset_n ? flags_q  : '0;

    assign alu_op       = reset_n ? op_q    : '0;
    assign alu_num1     = reset_n ? num1_q  : '0;
    assign alu_num2     = reset_n ? num2_q  : '0;
    assign alu_shamt    = reset_n ? shamt_q : '0;

    assign busy         = reset_n && busy_q;
    assign op_count     = op_count_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, meaning 0 = round-robin arbitration, 1 = port 0 always wins ties.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  operation accepted this cycle when reqN_valid && reqN_ready.
REQ-006 reqN_op  input  5  ALU opcode (`ALU_* encoding from alu.h).
REQ-007 reqN_num1, reqN_num2  input  32 each  operands.
REQ-008 reqN_shamt  input  5  immediate shift amount.
REQ-009 respN_valid  output  1  result for requester N is available.
REQ-010 respN_ready  input  1  requester N consumes result when respN_valid && respN_ready.
REQ-011 respN_result  output  32  ALU result.
REQ-012 respN_flags  output  3  {op_invalid, sig_overflow, overflow} captured with the result.
REQ-013 alu_op  output  5; alu_num1, alu_num2  output  32 each; alu_shamt  output  5: drive the shared combinational ALU.
REQ-014 alu_result  input  32; alu_overflow, alu_sig_overflow, alu_op_invalid  input  1 each: ALU outputs.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 op_count  output  16  count of completed (consumed) responses.

Function
REQ-017 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-018 IDLE: if any reqN_valid, grant one port; reqN_ready = (state==IDLE) && grantN, combinational from valids; all other reqN_ready low.
REQ-019 Grant, FIXED_PRIO=1: port 0 if req0_valid, else port 1.
REQ-020 Grant, FIXED_PRIO=0: single requester wins; both valid -> port not granted last (last_grant register).
REQ-021 On accept: latch op, num1, num2, shamt, granted port id into operand registers; update last_grant; IDLE -> EXEC.
REQ-022 alu_* outputs driven from operand registers at all times; values hold when not in EXEC.
REQ-023 EXEC (exactly 1 cycle): capture alu_result and {alu_op_invalid, alu_sig_overflow, alu_overflow} into response registers; EXEC -> RESP.
REQ-024 Latency: accept at edge of cycle T -> respN_valid high in cycle T+2.
REQ-025 RESP: respN_valid high for the owning port only; result/flags stable until consumed.
REQ-026 RESP with respN_ready high: response consumed, op_count += 1 (wraps 0xFFFF -> 0x0000), RESP -> IDLE; no new accept in that cycle.
REQ-027 RESP with respN_ready low: remain in RESP indefinitely (backpressure); reqN_ready stays low for both ports.
REQ-028 respN_ready of the non-owning port ignored; reqN_valid ignored outside IDLE.
REQ-029 op_invalid flag is passed through only; invalid opcodes complete normally with result 0.
REQ-030 Minimum issue interval 3 cycles per operation.

Reset
REQ-031 reset_n low at rising edge: state=IDLE, last_grant=1 (port 0 wins first tie), operand/response registers=0, op_count=0.
REQ-032 While in reset all outputs: reqN_ready=0, respN_valid=0, respN_result=0, respN_flags=0, busy=0, alu_* = 0.
REQ-033 Reset in EXEC or RESP discards the in-flight operation; no response is ever issued for it.

Verification
REQ-034 Single op: req0 ADD num1=5 num2=7 accepted cycle T, resp0_ready=1 -> resp0_valid in T+2, result=12, flags=000, op_count=1.
REQ-035 Tie, round-robin: both valid every IDLE, 4 ops -> grants 0,1,0,1; FIXED_PRIO=1 -> grants 0,0,0,0.
REQ-036 Overflow: req1 ADD 0x7FFFFFFF + 1 -> resp1_result=0x80000000, sig_overflow=1, overflow=0.
REQ-037 Backpressure: resp0_ready low 10 cycles -> resp0_valid and result held, req1_ready low throughout; raise resp0_ready -> IDLE next cycle, req1 then accepted.
REQ-038 Reset in RESP: assert reset_n=0 one cycle with resp0_valid high -> all outputs 0, no response after release, op_count=0.
REQ-039 Wrap and invalid op: preload 0xFFFF completions then one more -> op_count=0; unsupported opcode -> result=0, op_invalid=1.
